// File: rtl/control_word_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : control_word_sequencer_if
// Description : Completed-write bus from the bus control logic into the
//               command-word sequencer (request level, address bit, data).
// Revision    : 1.0 - initial release
// ============================================================================
interface control_word_sequencer_if;
    logic       wr_req;   // high while a chip-selected write is active
    logic       a0;       // address bit of the write
    logic [7:0] din;      // write data from the data bus buffer

    // Bus control logic side
    modport master (output wr_req, output a0, output din);
    // Sequencer side
    modport slave  (input wr_req, input a0, input din);
endinterface
`default_nettype wire

// File: rtl/control_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_word_sequencer
// Description : Runs the 8259A ICW1..ICW4 initialization sequence from
//               committed bus writes, then decodes OCW1/OCW2/OCW3. Holds all
//               command-word state and emits one-cycle command pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module control_word_sequencer #(
    parameter logic [7:0] IMR_INIT    = 8'h00,
    parameter logic [4:0] VECTOR_INIT = 5'h00
) (
    input  logic                          clk,
    input  logic                          reset_bar,
    control_word_sequencer_if.slave       bus,
    output logic                          init_done,
    output logic                          icw1_pulse,
    output logic                          ltim,
    output logic                          sngl,
    output logic                          ic4,
    output logic [4:0]                    vector_base,
    output logic [7:0]                    cascade_cfg,
    output logic                          upm,
    output logic                          aeoi,
    output logic                          ms,
    output logic                          buf_mode,
    output logic                          sfnm,
    output logic [7:0]                    imr,
    output logic                          ocw2_pulse,
    output logic [2:0]                    ocw2_cmd,
    output logic [2:0]                    ocw2_level,
    output logic                          special_mask,
    output logic                          read_isr,
    output logic                          poll_pulse
);

    localparam logic [2:0] c_ST_UNINIT    = 3'd0;
    localparam logic [2:0] c_ST_WAIT_ICW2 = 3'd1;
    localparam logic [2:0] c_ST_WAIT_ICW3 = 3'd2;
    localparam logic [2:0] c_ST_WAIT_ICW4 = 3'd3;
    localparam logic [2:0] c_ST_READY     = 3'd4;

    logic [2:0] r_state;
    logic       r_wr_req_q;
    logic       r_a0_q;
    logic [7:0] r_din_q;

    logic w_commit;
    logic w_is_icw1;
    logic w_is_ocw2;
    logic w_is_ocw3;

    // A write takes effect when the request level falls; the last captured
    // address/data while the request was high is what gets decoded.
    assign w_commit  = r_wr_req_q & ~bus.wr_req;
    assign w_is_icw1 = ~r_a0_q &  r_din_q[4];
    assign w_is_ocw2 = ~r_a0_q & ~r_din_q[4] & ~r_din_q[3];
    assign w_is_ocw3 = ~r_a0_q & ~r_din_q[4] &  r_din_q[3];

    // Capture the write in flight and delay the request for edge detection
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            r_wr_req_q <= 1'b0;
            r_a0_q     <= 1'b0;
            r_din_q    <= 8'h00;
        end else begin
            r_wr_req_q <= bus.wr_req;
            if (bus.wr_req) begin
                r_a0_q  <= bus.a0;
                r_din_q <= bus.din;
            end
        end
    end

    // Initialization sequencer and command-word register file
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            r_state      <= c_ST_UNINIT;
            init_done    <= 1'b0;
            icw1_pulse   <= 1'b0;
            ltim         <= 1'b0;
            sngl         <= 1'b0;
            ic4          <= 1'b0;
            vector_base  <= VECTOR_INIT;
            cascade_cfg  <= 8'h00;
            upm          <= 1'b0;
            aeoi         <= 1'b0;
            ms           <= 1'b0;
            buf_mode     <= 1'b0;
            sfnm         <= 1'b0;
            imr          <= IMR_INIT;
            ocw2_pulse   <= 1'b0;
            ocw2_cmd     <= 3'b000;
            ocw2_level   <= 3'b000;
            special_mask <= 1'b0;
            read_isr     <= 1'b0;
            poll_pulse   <= 1'b0;
        end else begin
            icw1_pulse <= 1'b0;
            ocw2_pulse <= 1'b0;
            poll_pulse <= 1'b0;

            if (w_commit) begin
                if (w_is_icw1) begin
                    // ICW1 restarts initialization from any state
                    ltim         <= r_din_q[3];
                    sngl         <= r_din_q[1];
                    ic4          <= r_din_q[0];
                    imr          <= IMR_INIT;
                    upm          <= 1'b0;
                    aeoi         <= 1'b0;
                    ms           <= 1'b0;
                    buf_mode     <= 1'b0;
                    sfnm         <= 1'b0;
                    special_mask <= 1'b0;
                    read_isr     <= 1'b0;
                    init_done    <= 1'b0;
                    icw1_pulse   <= 1'b1;
                    r_state      <= c_ST_WAIT_ICW2;
                end else begin
                    case (r_state)
                        c_ST_UNINIT: begin
                            // Nothing but ICW1 is meaningful before init
                        end
                        c_ST_WAIT_ICW2: begin
                            if (r_a0_q) begin
                                vector_base <= r_din_q[7:3];
                                if (!sngl) begin
                                    r_state <= c_ST_WAIT_ICW3;
                                end else if (ic4) begin
                                    r_state <= c_ST_WAIT_ICW4;
                                end else begin
                                    r_state   <= c_ST_READY;
                                    init_done <= 1'b1;
                                end
                            end
                        end
                        c_ST_WAIT_ICW3: begin
                            if (r_a0_q) begin
                                cascade_cfg <= r_din_q;
                                if (ic4) begin
                                    r_state <= c_ST_WAIT_ICW4;
                                end else begin
                                    r_state   <= c_ST_READY;
                                    init_done <= 1'b1;
                                end
                            end
                        end
                        c_ST_WAIT_ICW4: begin
                            if (r_a0_q) begin
                                sfnm      <= r_din_q[4];
                                buf_mode  <= r_din_q[3];
                                ms        <= r_din_q[2];
                                aeoi      <= r_din_q[1];
                                upm       <= r_din_q[0];
                                r_state   <= c_ST_READY;
                                init_done <= 1'b1;
                            end
                        end
                        c_ST_READY: begin
                            if (r_a0_q) begin
                                imr <= r_din_q;
                            end else if (w_is_ocw2) begin
                                ocw2_pulse <= 1'b1;
                                ocw2_cmd   <= r_din_q[7:5];
                                ocw2_level <= r_din_q[2:0];
                            end else if (w_is_ocw3) begin
                                // ESMM/RR gate their flag updates; P is a pulse
                                if (r_din_q[6]) begin
                                    special_mask <= r_din_q[5];
                                end
                                if (r_din_q[1]) begin
                                    read_isr <= r_din_q[0];
                                end
                                poll_pulse <= r_din_q[2];
                            end
                        end
                        default: begin
                            r_state   <= c_ST_UNINIT;
                            init_done <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_word_sequencer
// Description : Self-checking bench for control_word_sequencer: hand-derived
//               vector table, multi-cycle corner sequences and a randomized
//               run against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_word_sequencer;

    typedef struct packed {
        logic       icw1p;
        logic       ocw2p;
        logic       pollp;
        logic       init;
        logic [2:0] ibits;   // {ltim, sngl, ic4}
        logic [4:0] vb;
        logic [7:0] cas;
        logic [4:0] icw4;    // {sfnm, buf_mode, ms, aeoi, upm}
        logic [7:0] imr;
        logic       sm;
        logic       ris;
        logic [2:0] cmd;
        logic [2:0] lvl;
    } exp_t;

    typedef struct packed {
        logic       a0;
        logic [7:0] din;
        exp_t       e;
    } vec_t;

    logic       clk;
    logic       reset_bar;
    logic       init_done, icw1_pulse, ltim, sngl, ic4;
    logic [4:0] vector_base;
    logic [7:0] cascade_cfg;
    logic       upm, aeoi, ms, buf_mode, sfnm;
    logic [7:0] imr;
    logic       ocw2_pulse;
    logic [2:0] ocw2_cmd, ocw2_level;
    logic       special_mask, read_isr, poll_pulse;

    int total;
    int bad;

    control_word_sequencer_if bus ();

    control_word_sequencer dut (
        .clk          (clk),
        .reset_bar    (reset_bar),
        .bus          (bus),
        .init_done    (init_done),
        .icw1_pulse   (icw1_pulse),
        .ltim         (ltim),
        .sngl         (sngl),
        .ic4          (ic4),
        .vector_base  (vector_base),
        .cascade_cfg  (cascade_cfg),
        .upm          (upm),
        .aeoi         (aeoi),
        .ms           (ms),
        .buf_mode     (buf_mode),
        .sfnm         (sfnm),
        .imr          (imr),
        .ocw2_pulse   (ocw2_pulse),
        .ocw2_cmd     (ocw2_cmd),
        .ocw2_level   (ocw2_level),
        .special_mask (special_mask),
        .read_isr     (read_isr),
        .poll_pulse   (poll_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (transaction level) ----------------
    int         m_pending[$];   // ICW numbers still expected, in order
    logic       m_init, m_ltim, m_sngl, m_ic4, m_sm, m_ris;
    logic       m_p_icw1, m_p_ocw2, m_p_poll;
    logic [4:0] m_vb, m_icw4;
    logic [7:0] m_cas, m_imr;
    logic [2:0] m_cmd, m_lvl;

    task automatic model_reset();
        m_pending.delete();
        m_init = 0; m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_sm = 0; m_ris = 0;
        m_p_icw1 = 0; m_p_ocw2 = 0; m_p_poll = 0;
        m_vb = 5'h00; m_icw4 = 5'h00; m_cas = 8'h00; m_imr = 8'h00;
        m_cmd = 3'b000; m_lvl = 3'b000;
    endtask

    task automatic model_write(input logic a, input logic [7:0] d);
        int k;
        m_p_icw1 = 0; m_p_ocw2 = 0; m_p_poll = 0;
        if (!a && d[4]) begin
            m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
            m_imr = 8'h00; m_icw4 = 5'h00; m_sm = 0; m_ris = 0; m_init = 0;
            m_p_icw1 = 1;
            m_pending.delete();
            m_pending.push_back(2);
            if (!d[1]) m_pending.push_back(3);
            if (d[0])  m_pending.push_back(4);
        end else if (m_pending.size() > 0) begin
            if (a) begin
                k = m_pending.pop_front();
                if (k == 2)      m_vb   = d[7:3];
                else if (k == 3) m_cas  = d;
                else             m_icw4 = d[4:0];
                if (m_pending.size() == 0) m_init = 1;
            end
        end else if (m_init) begin
            if (a) begin
                m_imr = d;
            end else if (!d[3]) begin
                m_p_ocw2 = 1; m_cmd = d[7:5]; m_lvl = d[2:0];
            end else begin
                if (d[6]) m_sm  = d[5];
                if (d[1]) m_ris = d[0];
                m_p_poll = d[2];
            end
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.icw1p = m_p_icw1; e.ocw2p = m_p_ocw2; e.pollp = m_p_poll;
        e.init  = m_init;   e.ibits = {m_ltim, m_sngl, m_ic4};
        e.vb    = m_vb;     e.cas   = m_cas;   e.icw4 = m_icw4;
        e.imr   = m_imr;    e.sm    = m_sm;    e.ris  = m_ris;
        e.cmd   = m_cmd;    e.lvl   = m_lvl;
        return e;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input exp_t e);
        chk("icw1_pulse",   32'(icw1_pulse),   32'(e.icw1p));
        chk("ocw2_pulse",   32'(ocw2_pulse),   32'(e.ocw2p));
        chk("poll_pulse",   32'(poll_pulse),   32'(e.pollp));
        chk("init_done",    32'(init_done),    32'(e.init));
        chk("icw1_bits",    32'({ltim, sngl, ic4}), 32'(e.ibits));
        chk("vector_base",  32'(vector_base),  32'(e.vb));
        chk("cascade_cfg",  32'(cascade_cfg),  32'(e.cas));
        chk("icw4_bits",    32'({sfnm, buf_mode, ms, aeoi, upm}), 32'(e.icw4));
        chk("imr",          32'(imr),          32'(e.imr));
        chk("special_mask", 32'(special_mask), 32'(e.sm));
        chk("read_isr",     32'(read_isr),     32'(e.ris));
        if (e.ocw2p) begin
            chk("ocw2_cmd",   32'(ocw2_cmd),   32'(e.cmd));
            chk("ocw2_level", 32'(ocw2_level), 32'(e.lvl));
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the commit edge
    task automatic do_write(input logic a, input logic [7:0] d, input int hold);
        bus.wr_req = 1'b1; bus.a0 = a; bus.din = d;
        repeat (hold) @(posedge clk);
        #1;
        bus.wr_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One cycle after a commit every pulse must be back low
    task automatic pulse_gap();
        @(posedge clk);
        #1;
        chk("pulses_one_cycle", 32'({icw1_pulse, ocw2_pulse, poll_pulse}), 32'd0);
    endtask

    function automatic vec_t row(input logic a, input logic [7:0] d,
                                 input logic ip, input logic op, input logic pp, input logic ini,
                                 input logic [2:0] ib, input logic [4:0] vb, input logic [7:0] cas,
                                 input logic [4:0] i4, input logic [7:0] im, input logic sm,
                                 input logic ris, input logic [2:0] cmd, input logic [2:0] lvl);
        vec_t v;
        v.a0 = a; v.din = d;
        v.e.icw1p = ip; v.e.ocw2p = op; v.e.pollp = pp; v.e.init = ini;
        v.e.ibits = ib; v.e.vb = vb; v.e.cas = cas; v.e.icw4 = i4; v.e.imr = im;
        v.e.sm = sm; v.e.ris = ris; v.e.cmd = cmd; v.e.lvl = lvl;
        return v;
    endfunction

    task automatic apply_reset();
        bus.wr_req = 1'b0; bus.a0 = 1'b0; bus.din = 8'h00;
        reset_bar = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_bar = 1'b1;
        model_reset();
    endtask

    vec_t tbl[18];

    initial begin
        exp_t e0;
        total = 0;
        bad   = 0;

        // a0, din, icw1p, ocw2p, pollp, init, {ltim,sngl,ic4}, vb, cas, icw4, imr, sm, ris, cmd, lvl
        tbl[0]  = row(0, 8'h13, 1,0,0,0, 3'b011, 5'h00, 8'h00, 5'h00, 8'h00, 0,0, 3'd0, 3'd0);
        tbl[1]  = row(1, 8'h40, 0,0,0,0, 3'b011, 5'h08, 8'h00, 5'h00, 8'h00, 0,0, 3'd0, 3'd0);
        tbl[2]  = row(1, 8'h03, 0,0,0,1, 3'b011, 5'h08, 8'h00, 5'h03, 8'h00, 0,0, 3'd0, 3'd0);
        tbl[3]  = row(1, 8'hA5, 0,0,0,1, 3'b011, 5'h08, 8'h00, 5'h03, 8'hA5, 0,0, 3'd0, 3'd0);
        tbl[4]  = row(0, 8'h20, 0,1,0,1, 3'b011, 5'h08, 8'h00, 5'h03, 8'hA5, 0,0, 3'b001, 3'd0);
        tbl[5]  = row(0, 8'h68, 0,0,0,1, 3'b011, 5'h08, 8'h00, 5'h03, 8'hA5, 1,0, 3'd0, 3'd0);
        tbl[6]  = row(0, 8'h0B, 0,0,0,1, 3'b011, 5'h08, 8'h00, 5'h03, 8'hA5, 1,1, 3'd0, 3'd0);
        tbl[7]  = row(0, 8'h0C, 0,0,1,1, 3'b011, 5'h08, 8'h00, 5'h03, 8'hA5, 1,1, 3'd0, 3'd0);
        tbl[8]  = row(0, 8'h10, 1,0,0,0, 3'b000, 5'h08, 8'h00, 5'h00, 8'h00, 0,0, 3'd0, 3'd0);
        tbl[9]  = row(1, 8'h20, 0,0,0,0, 3'b000, 5'h04, 8'h00, 5'h00, 8'h00, 0,0, 3'd0, 3'd0);
        tbl[10] = row(0, 8'h20, 0,0,0,0, 3'b000, 5'h04, 8'h00, 5'h00, 8'h00, 0,0, 3'd0, 3'd0);
        tbl[11] = row(1, 8'h04, 0,0,0,1, 3'b000, 5'h04, 8'h04, 5'h00, 8'h00, 0,0, 3'd0, 3'd0);
        tbl[12] = row(0, 8'h13, 1,0,0,0, 3'b011, 5'h04, 8'h04, 5'h00, 8'h00, 0,0, 3'd0, 3'd0);
        tbl[13] = row(1, 8'hF8, 0,0,0,0, 3'b011, 5'h1F, 8'h04, 5'h00, 8'h00, 0,0, 3'd0, 3'd0);
        tbl[14] = row(0, 8'h10, 1,0,0,0, 3'b000, 5'h1F, 8'h04, 5'h00, 8'h00, 0,0, 3'd0, 3'd0);
        tbl[15] = row(1, 8'hA5, 0,0,0,0, 3'b000, 5'h14, 8'h04, 5'h00, 8'h00, 0,0, 3'd0, 3'd0);
        tbl[16] = row(1, 8'hFF, 0,0,0,1, 3'b000, 5'h14, 8'hFF, 5'h00, 8'h00, 0,0, 3'd0, 3'd0);
        tbl[17] = row(0, 8'hE3, 0,1,0,1, 3'b000, 5'h14, 8'hFF, 5'h00, 8'h00, 0,0, 3'b111, 3'b011);

        // ---- reset state ----
        apply_reset();
        e0 = '0;
        check_state(e0);
        chk("reset_ocw2_fields", 32'({ocw2_cmd, ocw2_level}), 32'd0);

        // ---- vector table ----
        for (int i = 0; i < 18; i++) begin
            do_write(tbl[i].a0, tbl[i].din, 1 + (i % 2));
            check_state(tbl[i].e);
            pulse_gap();
        end

        // ---- request held high: commit only on the fall, last data wins ----
        bus.wr_req = 1'b1; bus.a0 = 1'b1; bus.din = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        chk("held_no_commit", 32'(imr), 32'h00);
        bus.din = 8'h3C;
        @(posedge clk);
        #1;
        bus.wr_req = 1'b0;
        @(posedge clk);
        #1;
        chk("held_commit_imr", 32'(imr), 32'h3C);
        pulse_gap();

        // ---- asynchronous reset in the middle of ICW3 ----
        do_write(0, 8'h18, 1);   // ltim=1, cascade, no ICW4
        pulse_gap();
        do_write(1, 8'h48, 1);   // vector_base=9, now waiting for ICW3
        chk("pre_reset_vb", 32'(vector_base), 32'h09);
        bus.wr_req = 1'b1; bus.a0 = 1'b1; bus.din = 8'h04;
        @(posedge clk);
        #3;
        reset_bar = 1'b0;
        #1;
        chk("async_rst_vb",   32'(vector_base), 32'h00);
        chk("async_rst_ltim", 32'(ltim), 32'd0);
        chk("async_rst_init", 32'(init_done), 32'd0);
        chk("async_rst_imr",  32'(imr), 32'h00);
        bus.wr_req = 1'b0;
        @(posedge clk);
        #1;
        reset_bar = 1'b1;
        model_reset();
        do_write(1, 8'h77, 1);   // A0=1 before ICW1 is ignored
        chk("uninit_a0_imr", 32'(imr), 32'h00);
        chk("uninit_a0_cas", 32'(cascade_cfg), 32'h00);
        chk("uninit_a0_vb",  32'(vector_base), 32'h00);
        pulse_gap();
        do_write(0, 8'h20, 1);   // OCW2 before init: no pulse
        chk("uninit_ocw2", 32'(ocw2_pulse), 32'd0);
        pulse_gap();

        // ---- randomized run against the reference model ----
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            int         sel;
            logic       a;
            logic [7:0] d;
            sel = $urandom_range(0, 9);
            d   = 8'($urandom);
            if (sel == 0) begin
                a = 1'b0; d[4] = 1'b1;
            end else if (sel <= 5) begin
                a = 1'b1;
            end else begin
                a = 1'b0; d[4] = 1'b0;
            end
            model_write(a, d);
            do_write(a, d, $urandom_range(1, 3));
            check_state(model_exp());
            pulse_gap();
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
